// File: rtl/tile_cmd_sequencer.sv
// Self-sequencing address/command engine for an ARR_DIM x ARR_DIM systolic tile.
// Walks every (i,j) tile of OUT = IN1 * IN2 and streams wload, in-read and out read/write commands.
module tile_cmd_sequencer #(
  parameter int ARR_DIM  = 4,
  parameter int DIM_BITS = 4,
  parameter int ADDR_W   = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIM_BITS-1:0]        M,
  input  logic [DIM_BITS-1:0]        N,
  input  logic [DIM_BITS-1:0]        K,
  input  logic [ADDR_W-1:0]          base_in1,
  input  logic [ADDR_W-1:0]          base_in2,
  input  logic [ADDR_W-1:0]          base_out,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [1:0]                 cmd_kind,
  output logic [$clog2(ARR_DIM)-1:0] cmd_lane,
  output logic [$clog2(ARR_DIM)-1:0] cmd_row,
  output logic [DIM_BITS-1:0]        tile_i,
  output logic [DIM_BITS-1:0]        tile_j,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int LW   = $clog2(ARR_DIM);
  localparam int RW   = (DIM_BITS > LW) ? DIM_BITS : LW;
  localparam int WIDE = ADDR_W + 2 * DIM_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WLOAD, S_INRD, S_OUTRW, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    KIND_WLOAD = 2'b00,
    KIND_INRD  = 2'b01,
    KIND_ORD   = 2'b10,
    KIND_OWR   = 2'b11
  } kind_e;

  state_e              state_q, state_d;
  logic [DIM_BITS-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [ADDR_W-1:0]   b1_q, b1_d, b2_q, b2_d, bo_q, bo_d;
  logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d;
  logic [RW-1:0]       r_q, r_d;
  logic [LW-1:0]       c_q, c_d;
  logic                rd_ph_q, rd_ph_d;

  logic                cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  kind_e               cmd_kind_q, cmd_kind_d;
  logic [LW-1:0]       cmd_lane_q, cmd_lane_d;
  logic [LW-1:0]       cmd_row_q, cmd_row_d;
  logic [DIM_BITS-1:0] tile_i_q, tile_i_d, tile_j_q, tile_j_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [WIDE-1:0]     addr_lim, end_in1, end_in2, end_out;
  logic [DIM_BITS-1:0] n_tiles, k_tiles;
  logic                bad_job, xfer;
  logic                last_c, last_r, last_h, last_i, last_j;

  // Range sums are carried at full width so an overflow past the address space is visible.
  assign addr_lim = WIDE'(1) << ADDR_W;
  assign end_in1  = WIDE'(b1_q) + WIDE'(m_q) * WIDE'(n_q);
  assign end_in2  = WIDE'(b2_q) + WIDE'(n_q) * WIDE'(k_q);
  assign end_out  = WIDE'(bo_q) + WIDE'(m_q) * WIDE'(k_q);

  assign bad_job = (m_q == '0) || (n_q == '0) || (k_q == '0)
                || (|n_q[LW-1:0]) || (|k_q[LW-1:0])
                || (end_in1 > addr_lim) || (end_in2 > addr_lim) || (end_out > addr_lim);

  assign n_tiles = n_q >> LW;
  assign k_tiles = k_q >> LW;
  assign xfer    = cmd_valid_q && cmd_ready;
  assign last_c  = (c_q == LW'(ARR_DIM - 1));
  assign last_r  = (r_q == RW'(ARR_DIM - 1));
  assign last_h  = (r_q == RW'(m_q) - RW'(1));
  assign last_i  = (i_q == n_tiles - DIM_BITS'(1));
  assign last_j  = (j_q == k_tiles - DIM_BITS'(1));

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    bo_d    = bo_q;
    i_d     = i_q;
    j_d     = j_q;
    r_d     = r_q;
    c_d     = c_q;
    rd_ph_d = rd_ph_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          m_d     = M;
          n_d     = N;
          k_d     = K;
          b1_d    = base_in1;
          b2_d    = base_in2;
          bo_d    = base_out;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_job) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WLOAD;
          i_d     = '0;
          j_d     = '0;
          r_d     = '0;
          c_d     = '0;
          rd_ph_d = 1'b0;
        end
      end
      S_WLOAD: begin
        if (xfer) begin
          c_d = c_q + LW'(1);
          if (last_c) begin
            r_d = last_r ? '0 : r_q + RW'(1);
            if (last_r) state_d = S_INRD;
          end
        end
      end
      S_INRD: begin
        if (xfer) begin
          c_d = c_q + LW'(1);
          if (last_c) begin
            r_d = last_h ? '0 : r_q + RW'(1);
            if (last_h) begin
              state_d = S_OUTRW;
              rd_ph_d = (i_q != '0);
            end
          end
        end
      end
      S_OUTRW: begin
        // Beyond the first N-tile each lane is read back before the accumulated write.
        if (xfer) begin
          if (rd_ph_q) begin
            rd_ph_d = 1'b0;
          end else begin
            c_d     = c_q + LW'(1);
            rd_ph_d = (i_q != '0);
            if (last_c) begin
              r_d = last_h ? '0 : r_q + RW'(1);
              if (last_h) begin
                rd_ph_d = 1'b0;
                if (!last_j) begin
                  j_d     = j_q + DIM_BITS'(1);
                  state_d = S_WLOAD;
                end else if (!last_i) begin
                  j_d     = '0;
                  i_d     = i_q + DIM_BITS'(1);
                  state_d = S_WLOAD;
                end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // Output fields are decoded from the next position so they register alongside the counters.
  always_comb begin
    cmd_addr_d = '0;
    cmd_kind_d = KIND_WLOAD;
    case (state_d)
      S_WLOAD: begin
        cmd_addr_d = ADDR_W'(WIDE'(b2_q)
                   + (WIDE'(i_d) * WIDE'(ARR_DIM) + WIDE'(r_d)) * WIDE'(k_q)
                   + WIDE'(j_d) * WIDE'(ARR_DIM) + WIDE'(c_d));
      end
      S_INRD: begin
        cmd_kind_d = KIND_INRD;
        cmd_addr_d = ADDR_W'(WIDE'(b1_q) + WIDE'(r_d) * WIDE'(n_q)
                   + WIDE'(i_d) * WIDE'(ARR_DIM) + WIDE'(c_d));
      end
      S_OUTRW: begin
        cmd_kind_d = rd_ph_d ? KIND_ORD : KIND_OWR;
        cmd_addr_d = ADDR_W'(WIDE'(bo_q) + WIDE'(r_d) * WIDE'(k_q)
                   + WIDE'(j_d) * WIDE'(ARR_DIM) + WIDE'(c_d));
      end
      default: ;
    endcase

    cmd_valid_d = (state_d == S_WLOAD) || (state_d == S_INRD) || (state_d == S_OUTRW);
    busy_d      = cmd_valid_d || (state_d == S_CHECK);
    cmd_lane_d  = cmd_valid_d ? c_d : '0;
    cmd_row_d   = (state_d == S_WLOAD) ? r_d[LW-1:0] : '0;
    tile_i_d    = cmd_valid_d ? i_d : tile_i_q;
    tile_j_d    = cmd_valid_d ? j_d : tile_j_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      bo_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      rd_ph_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_kind_q  <= KIND_WLOAD;
      cmd_lane_q  <= '0;
      cmd_row_q   <= '0;
      tile_i_q    <= '0;
      tile_j_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      bo_q        <= bo_d;
      i_q         <= i_d;
      j_q         <= j_d;
      r_q         <= r_d;
      c_q         <= c_d;
      rd_ph_q     <= rd_ph_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_kind_q  <= cmd_kind_d;
      cmd_lane_q  <= cmd_lane_d;
      cmd_row_q   <= cmd_row_d;
      tile_i_q    <= tile_i_d;
      tile_j_q    <= tile_j_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_kind  = cmd_kind_q;
  assign cmd_lane  = cmd_lane_q;
  assign cmd_row   = cmd_row_q;
  assign tile_i    = tile_i_q;
  assign tile_j    = tile_j_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tile_cmd_sequencer.sv
// Directed bench for tile_cmd_sequencer: job table with hand-computed counts and a loop-nest
// reference stream, plus hand-written abort, reset and start/abort-collision sequences.
module tb_tile_cmd_sequencer;

  localparam int A  = 4;
  localparam int DB = 4;
  localparam int AW = 10;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, cmd_ready;
  logic [DB-1:0] M, N, K, tile_i, tile_j;
  logic [AW-1:0] base_in1, base_in2, base_out, cmd_addr;
  logic          cmd_valid, busy, done, err;
  logic [1:0]    cmd_kind;
  logic [LW-1:0] cmd_lane, cmd_row;

  always #5 clk = ~clk;

  tile_cmd_sequencer #(.ARR_DIM(A), .DIM_BITS(DB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .M(M), .N(N), .K(K),
    .base_in1(base_in1), .base_in2(base_in2), .base_out(base_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_kind(cmd_kind), .cmd_lane(cmd_lane), .cmd_row(cmd_row),
    .tile_i(tile_i), .tile_j(tile_j), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    int kind; int addr; int lane; int row; int ti; int tj;
  } cmd_t;

  typedef struct {
    string name;
    int m; int n; int k; int b1; int b2; int bo;
    bit toggle; int poke; bit exp_err; int exp_cnt;
  } job_t;

  int   tests = 0;
  int   fails = 0;
  cmd_t got[$];
  cmd_t expq[$];
  int   last_xfer_cyc, done_cyc, err_cyc;
  job_t jobs[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int enc(input cmd_t c);
    return (c.kind << 22) | (c.addr << 12) | (c.lane << 10) | (c.row << 8) | (c.ti << 4) | c.tj;
  endfunction

  task automatic sample_cmd(output cmd_t c);
    c.kind = int'(cmd_kind);
    c.addr = int'(cmd_addr);
    c.lane = int'(cmd_lane);
    c.row  = int'(cmd_row);
    c.ti   = int'(tile_i);
    c.tj   = int'(tile_j);
  endtask

  task automatic push_exp(input int kind, input int addr, input int lane, input int row,
                          input int ti, input int tj);
    cmd_t c;
    c.kind = kind; c.addr = addr; c.lane = lane; c.row = row; c.ti = ti; c.tj = tj;
    expq.push_back(c);
  endtask

  task automatic build_exp(input job_t jb);
    expq.delete();
    for (int i = 0; i < jb.n / A; i++) begin
      for (int j = 0; j < jb.k / A; j++) begin
        for (int r = 0; r < A; r++)
          for (int c = 0; c < A; c++)
            push_exp(0, jb.b2 + (i * A + r) * jb.k + j * A + c, c, r, i, j);
        for (int h = 0; h < jb.m; h++)
          for (int c = 0; c < A; c++)
            push_exp(1, jb.b1 + h * jb.n + i * A + c, c, 0, i, j);
        for (int h = 0; h < jb.m; h++)
          for (int c = 0; c < A; c++) begin
            if (i > 0) push_exp(2, jb.bo + h * jb.k + j * A + c, c, 0, i, j);
            push_exp(3, jb.bo + h * jb.k + j * A + c, c, 0, i, j);
          end
      end
    end
  endtask

  task automatic launch(input job_t jb);
    @(posedge clk); #1;
    M = DB'(jb.m); N = DB'(jb.n); K = DB'(jb.k);
    base_in1 = AW'(jb.b1); base_in2 = AW'(jb.b2); base_out = AW'(jb.bo);
    start = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input job_t jb);
    int   cyc;
    bit   fin;
    bit   pv_stall;
    cmd_t cur;
    cmd_t pv;
    int   n;
    got.delete();
    last_xfer_cyc = -1; done_cyc = -1; err_cyc = -1;
    pv_stall = 1'b0; fin = 1'b0; cyc = 0;
    launch(jb);
    while (!fin && cyc < 600) begin
      cmd_ready = jb.toggle ? (cyc % 2 == 1) : 1'b1;
      start = (jb.poke > 0) && (cyc == jb.poke);
      @(negedge clk);
      sample_cmd(cur);
      if (pv_stall) begin
        check($sformatf("%s.stall_valid", jb.name), int'(cmd_valid), 1);
        check($sformatf("%s.stall_fields", jb.name), enc(cur), enc(pv));
      end
      if (cmd_valid && cmd_ready) begin
        got.push_back(cur);
        last_xfer_cyc = cyc;
      end
      pv_stall = cmd_valid && !cmd_ready;
      pv = cur;
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
        check($sformatf("%s.done_busy", jb.name), int'(busy), 0);
        check($sformatf("%s.done_valid", jb.name), int'(cmd_valid), 0);
      end
      if (err) begin
        err_cyc = cyc;
        fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    cmd_ready = 1'b1;
    check($sformatf("%s.finished", jb.name), int'(fin), 1);
    @(negedge clk);
    check($sformatf("%s.pulse_end", jb.name), int'(done) + int'(err) + int'(busy), 0);
    check($sformatf("%s.err_seen", jb.name), int'(err_cyc >= 0), int'(jb.exp_err));
    check($sformatf("%s.count", jb.name), got.size(), jb.exp_cnt);
    if (jb.exp_err) begin
      check($sformatf("%s.err_latency", jb.name), err_cyc, 1);
    end else begin
      check($sformatf("%s.done_latency", jb.name), done_cyc, last_xfer_cyc + 1);
      build_exp(jb);
      n = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int x = 0; x < n; x++)
        check($sformatf("%s.cmd%0d", jb.name, x), enc(got[x]), enc(expq[x]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
    M = '0; N = '0; K = '0; base_in1 = '0; base_in2 = '0; base_out = '0;

    jobs[0] = '{"basic",      2, 4, 4,   0, 100,  200, 1'b0,  0, 1'b0, 32};
    jobs[1] = '{"toggle",     2, 4, 4,   0, 100,  200, 1'b1,  0, 1'b0, 32};
    jobs[2] = '{"accum",      1, 8, 4,   0,  64,  128, 1'b0,  0, 1'b0, 52};
    jobs[3] = '{"n6",         2, 6, 4,   0, 100,  200, 1'b0,  0, 1'b1,  0};
    jobs[4] = '{"out_ovf",    4, 4, 4,   0, 100, 1020, 1'b0,  0, 1'b1,  0};
    jobs[5] = '{"m0",         0, 4, 4,   0, 100,  200, 1'b0,  0, 1'b1,  0};
    jobs[6] = '{"exact_fit",  4, 4, 4,   0,  16, 1008, 1'b0,  0, 1'b0, 48};
    jobs[7] = '{"two_j_poke", 3, 4, 8,   0,  12,   44, 1'b0, 10, 1'b0, 80};
    jobs[8] = '{"in2_ovf",    1, 4, 4,   0, 1013,   0, 1'b0,  0, 1'b1,  0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.valid", int'(cmd_valid), 0);
    check("reset.busy",  int'(busy), 0);
    check("reset.done",  int'(done), 0);
    check("reset.err",   int'(err), 0);
    check("reset.addr",  int'(cmd_addr), 0);
    check("reset.tile",  int'(tile_i) + int'(tile_j), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 9; t++) begin
      run_job(jobs[t]);
      if (t == 0 && got.size() == 32) begin
        check("basic.first_wload", got[0].addr, 100);
        check("basic.last_wload",  got[15].addr, 115);
        check("basic.first_inrd",  enc(got[16]), (1 << 22) | (0 << 12));
        check("basic.last_write",  enc(got[31]), (3 << 22) | (207 << 12) | (3 << 10));
      end
      if (t == 2 && got.size() == 52) begin
        check("accum.tile1_wload", got[24].addr, 80);
        check("accum.tile1_ti",    got[24].ti, 1);
        check("accum.first_rd",    enc(got[44]), (2 << 22) | (128 << 12) | (1 << 4));
        check("accum.first_wr",    enc(got[45]), (3 << 22) | (128 << 12) | (1 << 4));
        check("accum.last_rd",     enc(got[50]), (2 << 22) | (131 << 12) | (3 << 10) | (1 << 4));
        check("accum.last_wr",     enc(got[51]), (3 << 22) | (131 << 12) | (3 << 10) | (1 << 4));
      end
    end

    // Abort while the 5th weight load is presented.
    launch(jobs[0]);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort.at_5th_valid", int'(cmd_valid), 1);
    check("abort.at_5th_addr",  int'(cmd_addr), 104);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort.valid_next", int'(cmd_valid), 0);
    check("abort.busy_next",  int'(busy), 0);
    saw = 1'b0;
    for (int x = 0; x < 4; x++) begin
      saw = saw | done | err;
      @(negedge clk);
    end
    check("abort.no_done_err", int'(saw), 0);
    run_job(jobs[0]);

    // start and abort together in IDLE must not launch.
    @(posedge clk); #1;
    M = 4'd2; N = 4'd4; K = 4'd4;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    saw = 1'b0;
    for (int x = 0; x < 4; x++) begin
      @(negedge clk);
      saw = saw | busy | cmd_valid | err;
    end
    check("start_abort.idle", int'(saw), 0);

    // Reset during the INRD phase of tile i=1.
    launch(jobs[2]);
    repeat (42) @(posedge clk);
    @(negedge clk);
    check("rst_mid.kind",   int'(cmd_kind), 1);
    check("rst_mid.addr",   int'(cmd_addr), 5);
    check("rst_mid.tile_i", int'(tile_i), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid.valid_after", int'(cmd_valid), 0);
    check("rst_mid.addr_after",  int'(cmd_addr), 0);
    check("rst_mid.kind_lane",   int'(cmd_kind) + int'(cmd_lane) + int'(cmd_row), 0);
    check("rst_mid.tile_after",  int'(tile_i) + int'(tile_j), 0);
    check("rst_mid.flags_after", int'(busy) + int'(done) + int'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(jobs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
